// File: rtl/dsm_scheduler_pkg.sv
// Shared FSM encoding and full-scale feedback constants for the stereo DSD modulator.
package dsm_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC_L = 2'd1,
    ST_CALC_R = 2'd2,
    ST_OUT    = 2'd3
  } state_e;

  // Full-scale values of a w-bit signed PCM word, callers size-cast to their width.
  function automatic logic signed [63:0] fs_pos(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fs_neg(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/dsm_delta.sv
// PCM sample minus full-scale DSD feedback; purely combinational, one bit wider than PCM.
module dsm_delta
  import dsm_scheduler_pkg::*;
#(
  parameter int PCM_Bit_Length = 32
) (
  input  logic signed [PCM_Bit_Length-1:0] pcm_i,
  input  logic                             fb_bit_i,
  output logic signed [PCM_Bit_Length:0]   delta_o
);

  localparam logic signed [PCM_Bit_Length:0] FB_POS = (PCM_Bit_Length + 1)'(fs_pos(PCM_Bit_Length));
  localparam logic signed [PCM_Bit_Length:0] FB_NEG = (PCM_Bit_Length + 1)'(fs_neg(PCM_Bit_Length));

  logic signed [PCM_Bit_Length:0] pcm_ext;

  assign pcm_ext = (PCM_Bit_Length + 1)'(pcm_i);
  assign delta_o = pcm_ext - (fb_bit_i ? FB_POS : FB_NEG);

endmodule

// File: rtl/dsm_scheduler.sv
// Stereo first-order delta-sigma modulator sharing one delta unit: L then R, 4 cycles per step.
// DSD_EN_I while busy is dropped and flagged on sticky OVERRUN_O.
module dsm_scheduler
  import dsm_scheduler_pkg::*;
#(
  parameter int PCM_Bit_Length = 32,
  parameter int ACC_Bit_Length = PCM_Bit_Length + 4
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic signed [PCM_Bit_Length-1:0] PCM_L_I,
  input  logic signed [PCM_Bit_Length-1:0] PCM_R_I,
  input  logic                             PCM_VALID_I,
  input  logic                             DSD_EN_I,
  output logic                             DSD_L_O,
  output logic                             DSD_R_O,
  output logic                             DSD_VALID_O,
  output logic                             BUSY_O,
  output logic                             OVERRUN_O
);

  localparam int PW = PCM_Bit_Length;
  localparam int AW = ACC_Bit_Length;
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW - 1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW - 1){1'b0}}};

  state_e               state_q, state_d;
  logic signed [PW-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic signed [PW-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic signed [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic                 bit_l_q, bit_l_d, bit_r_q, bit_r_d;
  logic                 dsd_l_q, dsd_l_d, dsd_r_q, dsd_r_d;
  logic                 dsd_vld_q, dsd_vld_d;
  logic                 overrun_q, overrun_d;

  logic                 calc_r;
  logic signed [PW-1:0] calc_pcm;
  logic                 calc_fb;
  logic signed [AW-1:0] acc_sel;
  logic signed [PW:0]   delta;
  logic signed [AW:0]   sum_wide;
  logic signed [AW-1:0] acc_sat;

  always_comb begin
    calc_r   = (state_q == ST_CALC_R);
    calc_pcm = calc_r ? act_r_q : act_l_q;
    calc_fb  = calc_r ? bit_r_q : bit_l_q;
    acc_sel  = calc_r ? acc_r_q : acc_l_q;
  end

  dsm_delta #(
    .PCM_Bit_Length(PW)
  ) u_delta (
    .pcm_i   (calc_pcm),
    .fb_bit_i(calc_fb),
    .delta_o (delta)
  );

  // One guard bit is enough: |delta| is far below the accumulator range.
  always_comb begin
    sum_wide = (AW + 1)'(acc_sel) + (AW + 1)'(delta);
    if (sum_wide[AW] != sum_wide[AW-1]) begin
      acc_sat = sum_wide[AW] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_sat = sum_wide[AW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_l_d  = pend_l_q;
    pend_r_d  = pend_r_q;
    act_l_d   = act_l_q;
    act_r_d   = act_r_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    bit_l_d   = bit_l_q;
    bit_r_d   = bit_r_q;
    dsd_l_d   = dsd_l_q;
    dsd_r_d   = dsd_r_q;
    dsd_vld_d = 1'b0;
    overrun_d = overrun_q | (DSD_EN_I & (state_q != ST_IDLE));

    if (PCM_VALID_I) begin
      pend_l_d = PCM_L_I;
      pend_r_d = PCM_R_I;
    end

    case (state_q)
      ST_IDLE: begin
        if (DSD_EN_I) begin
          state_d = ST_CALC_L;
          // A sample arriving with the strobe bypasses the pending register.
          act_l_d = PCM_VALID_I ? PCM_L_I : pend_l_q;
          act_r_d = PCM_VALID_I ? PCM_R_I : pend_r_q;
        end
      end
      ST_CALC_L: begin
        acc_l_d = acc_sat;
        bit_l_d = ~acc_sat[AW-1];
        state_d = ST_CALC_R;
      end
      ST_CALC_R: begin
        acc_r_d = acc_sat;
        bit_r_d = ~acc_sat[AW-1];
        state_d = ST_OUT;
      end
      ST_OUT: begin
        dsd_l_d   = bit_l_q;
        dsd_r_d   = bit_r_q;
        dsd_vld_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= ST_IDLE;
      pend_l_q  <= '0;
      pend_r_q  <= '0;
      act_l_q   <= '0;
      act_r_q   <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      bit_l_q   <= 1'b0;
      bit_r_q   <= 1'b0;
      dsd_l_q   <= 1'b0;
      dsd_r_q   <= 1'b0;
      dsd_vld_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_l_q  <= pend_l_d;
      pend_r_q  <= pend_r_d;
      act_l_q   <= act_l_d;
      act_r_q   <= act_r_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      bit_l_q   <= bit_l_d;
      bit_r_q   <= bit_r_d;
      dsd_l_q   <= dsd_l_d;
      dsd_r_q   <= dsd_r_d;
      dsd_vld_q <= dsd_vld_d;
      overrun_q <= overrun_d;
    end
  end

  assign DSD_L_O     = dsd_l_q;
  assign DSD_R_O     = dsd_r_q;
  assign DSD_VALID_O = dsd_vld_q;
  assign BUSY_O      = (state_q != ST_IDLE);
  assign OVERRUN_O   = overrun_q;

endmodule

// File: tb/tb_dsm_scheduler.sv
// Scoreboard bench for dsm_scheduler: directed scenarios then random traffic against a step-level model.
module tb_dsm_scheduler;

  localparam int PW = 16;
  localparam int AW = 20;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [PW-1:0] pcm_l, pcm_r;
  logic                 pcm_vld, dsd_en;
  logic                 dsd_l, dsd_r, dsd_vld, busy, ovr;

  dsm_scheduler #(
    .PCM_Bit_Length(PW),
    .ACC_Bit_Length(AW)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .PCM_L_I    (pcm_l),
    .PCM_R_I    (pcm_r),
    .PCM_VALID_I(pcm_vld),
    .DSD_EN_I   (dsd_en),
    .DSD_L_O    (dsd_l),
    .DSD_R_O    (dsd_r),
    .DSD_VALID_O(dsd_vld),
    .BUSY_O     (busy),
    .OVERRUN_O  (ovr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int exp_cyc;
    bit l;
    bit r;
  } exp_t;

  exp_t sb[$];
  bit   obs_l[$];
  bit   obs_r[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: integrators, last bits, pending sample, busy window, overrun onset.
  int m_acc[2];
  int m_prev[2];
  int m_pend[2];
  int busy_from, busy_until, ovr_at;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i]  = 0;
      m_prev[i] = 0;
      m_pend[i] = 0;
    end
    ovr_at = NEVER;
  endtask

  function automatic bit model_chan(input int ch, input int pcm);
    int fb;
    int a;
    fb = (m_prev[ch] != 0) ? 32767 : -32768;
    a  = m_acc[ch] + pcm - fb;
    if (a > 524287) a = 524287;
    if (a < -524288) a = -524288;
    m_acc[ch]  = a;
    m_prev[ch] = (a >= 0) ? 1 : 0;
    return (a >= 0);
  endfunction

  // Checks flags for the current cycle, drives inputs, updates the model, advances one clock.
  task automatic step_cyc(input bit en, input bit pv, input bit rs, input int l, input int r);
    chk("busy", busy, (cyc >= busy_from && cyc <= busy_until));
    chk("overrun", ovr, (cyc >= ovr_at));
    rst     = rs;
    dsd_en  = en;
    pcm_vld = pv;
    pcm_l   = PW'(l);
    pcm_r   = PW'(r);
    if (rs) begin
      while (sb.size() > 0 && sb[$].exp_cyc > cyc) void'(sb.pop_back());
      model_reset();
      if (busy_until > cyc) busy_until = cyc;
    end else begin
      if (pv) begin
        m_pend[0] = l;
        m_pend[1] = r;
      end
      if (en) begin
        if (cyc >= busy_from && cyc <= busy_until) begin
          if (ovr_at > cyc + 1) ovr_at = cyc + 1;
        end else begin
          exp_t e;
          e.exp_cyc = cyc + 4;
          e.l = model_chan(0, m_pend[0]);
          e.r = model_chan(1, m_pend[1]);
          sb.push_back(e);
          busy_from  = cyc + 1;
          busy_until = cyc + 3;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cyc(0, 0, 0, 0, 0);
  endtask

  task automatic run_steps(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step_cyc(1, 0, 0, 0, 0);
      idle(gap - 1);
    end
  endtask

  task automatic chk_seq8(input string name);
    int seq[8] = '{1, 1, 0, 1, 0, 1, 0, 1};
    chk({name, "_count"}, obs_l.size(), 8);
    for (int i = 0; i < 8 && i < obs_l.size(); i++) chk({name, "_bit"}, obs_l[i], seq[i]);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].exp_cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL dsd_valid_missing: no pulse seen, expected at cycle %0d (now %0d)", sb[0].exp_cyc, cyc);
        void'(sb.pop_front());
      end
      if (dsd_vld === 1'b1) begin
        obs_l.push_back(dsd_l);
        obs_r.push_back(dsd_r);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dsd_valid_unexpected: pulse at cycle %0d, expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("valid_cycle", cyc, e.exp_cyc);
          chk("dsd_l", dsd_l, e.l);
          chk("dsd_r", dsd_r, e.r);
        end
      end
    end
  endtask

  task automatic stim();
    rst = 1'b1; dsd_en = 1'b0; pcm_vld = 1'b0; pcm_l = '0; pcm_r = '0;
    model_reset();
    busy_from = -100; busy_until = -100;
    repeat (3) @(posedge clk);
    #1;
    step_cyc(0, 0, 1, 0, 0);
    chk("reset_dsd_l", dsd_l, 0);
    chk("reset_dsd_r", dsd_r, 0);
    chk("reset_valid", dsd_vld, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", ovr, 0);

    // Silence from reset: known limit-cycle pattern.
    obs_l.delete(); obs_r.delete();
    step_cyc(0, 1, 0, 0, 0);
    run_steps(8, 8);
    idle(6);
    chk_seq8("zero_seq");

    // Back-to-back strobe while busy: dropped, overrun sticky, single pulse.
    step_cyc(1, 0, 0, 0, 0);
    idle(1);
    step_cyc(1, 0, 0, 0, 0);
    idle(6);
    chk("overrun_sticky", ovr, 1);

    // Sample with strobe is used now; sample during CALC_R waits for next step.
    step_cyc(1, 1, 0, 1000, -1000);
    idle(1);
    step_cyc(0, 1, 0, -5000, 7000);
    idle(5);
    step_cyc(1, 0, 0, 0, 0);
    idle(6);

    // Reset during CALC_R aborts the step and restarts the modulator.
    step_cyc(0, 1, 0, 0, 0);
    step_cyc(1, 0, 0, 0, 0);
    idle(1);
    step_cyc(0, 0, 1, 0, 0);
    chk("abort_dsd_l", dsd_l, 0);
    chk("abort_valid", dsd_vld, 0);
    chk("abort_overrun", ovr, 0);
    obs_l.delete(); obs_r.delete();
    run_steps(8, 8);
    idle(6);
    chk_seq8("restart_seq");

    // Full-scale inputs at minimum strobe spacing.
    step_cyc(0, 0, 1, 0, 0);
    step_cyc(0, 1, 0, 32767, -32768);
    obs_l.delete(); obs_r.delete();
    run_steps(12, 4);
    idle(6);
    chk("fullscale_count", obs_l.size(), 12);
    for (int i = 0; i < obs_l.size(); i++) begin
      chk("fullscale_l", obs_l[i], 1);
      chk("fullscale_r", obs_r[i], (i == 0) ? 1 : 0);
    end

    // Random traffic, including extremes and occasional reset.
    for (int i = 0; i < 800; i++) begin
      bit en, pv, rs;
      int l, r;
      rs = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 2) == 0);
      pv = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: begin l = 32767; r = -32768; end
        1: begin l = -32768; r = 32767; end
        default: begin
          l = int'($urandom_range(0, 65535)) - 32768;
          r = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      step_cyc(en, pv, rs, l, r);
    end
    idle(8);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stim();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
